regfile_wb_arbiter: RTL and testbench

//  Shares the single write channel (ND/DI/REG_WE) of the 4x8 register file between two writeback

---
 rtl/regfile_wb_arbiter_if.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU result, memory load) and the
// register-file write channel, plus the pending-write mask seen by decode.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    localparam int NREG = 1 << ADDR_W;

    logic              a_valid;
    logic [ADDR_W-1:0] a_nd;
    logic [DATA_W-1:0] a_di;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_nd;
    logic [DATA_W-1:0] b_di;
    logic              b_ready;
    logic [ADDR_W-1:0] nd;
    logic [DATA_W-1:0] di;
    logic              reg_we;
    logic [NREG-1:0]   pending;

    modport master (
        output a_valid, a_nd, a_di, b_valid, b_nd, b_di,
        input  a_ready, b_ready, nd, di, reg_we, pending
    );

    modport slave (
        input  a_valid, a_nd, a_di, b_valid, b_nd, b_di,
        output a_ready, b_ready, nd, di, reg_we, pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter: one-entry buffer per side, oldest-first commit,
// round-robin between equal-age entries, registered write channel to the register file.
module regfile_wb_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input logic                  Clock,
    input logic                  Reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int NREG = 1 << ADDR_W;

    typedef enum logic [1:0] {OLD_TIE = 2'd0, OLD_A = 2'd1, OLD_B = 2'd2} old_t;

    logic              a_full_p0, b_full_p0;
    logic [ADDR_W-1:0] a_nd_p0, b_nd_p0;
    logic [DATA_W-1:0] a_di_p0, b_di_p0;
    old_t              old_q, old_d;
    logic              rr_q, rr_d;
    logic              gnt_a, gnt_b, tie;
    logic              a_ready, b_ready, acc_a, acc_b;
    logic              a_full_d, b_full_d;
    logic              vld_p1;
    logic [ADDR_W-1:0] nd_p1;
    logic [DATA_W-1:0] di_p1;
    logic [NREG-1:0]   pend;

    // Grant is decided purely from flops; rr_q=1 means B wins the next tie.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        tie   = 1'b0;
        if (a_full_p0 && b_full_p0) begin
            unique case (old_q)
                OLD_A:   gnt_a = 1'b1;
                OLD_B:   gnt_b = 1'b1;
                default: begin
                    tie = 1'b1;
                    if ((a_nd_p0 == b_nd_p0) || !rr_q) gnt_a = 1'b1;
                    else                               gnt_b = 1'b1;
                end
            endcase
        end else begin
            gnt_a = a_full_p0;
            gnt_b = b_full_p0;
        end
    end

    assign a_ready = ~a_full_p0 | gnt_a;
    assign b_ready = ~b_full_p0 | gnt_b;
    assign acc_a   = bus.a_valid & a_ready;
    assign acc_b   = bus.b_valid & b_ready;

    // A freshly loaded entry is always younger than one that stays.
    always_comb begin
        a_full_d = acc_a | (a_full_p0 & ~gnt_a);
        b_full_d = acc_b | (b_full_p0 & ~gnt_b);
        old_d    = old_q;
        if (a_full_d && b_full_d) begin
            if (acc_a && acc_b) old_d = OLD_TIE;
            else if (acc_a)     old_d = OLD_B;
            else if (acc_b)     old_d = OLD_A;
        end else if (a_full_d) begin
            old_d = OLD_A;
        end else if (b_full_d) begin
            old_d = OLD_B;
        end else begin
            old_d = OLD_TIE;
        end
        rr_d = tie ? gnt_a : rr_q;
    end

    // Stage p0 -> p1: buffer state and the registered write channel.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_full_p0 <= 1'b0;
            b_full_p0 <= 1'b0;
            old_q     <= OLD_TIE;
            rr_q      <= 1'b0;
            vld_p1    <= 1'b0;
            nd_p1     <= '0;
            di_p1     <= '0;
        end else begin
            a_full_p0 <= a_full_d;
            b_full_p0 <= b_full_d;
            old_q     <= old_d;
            rr_q      <= rr_d;
            vld_p1    <= gnt_a | gnt_b;
            if (gnt_a) begin
                nd_p1 <= a_nd_p0;
                di_p1 <= a_di_p0;
            end else if (gnt_b) begin
                nd_p1 <= b_nd_p0;
                di_p1 <= b_di_p0;
            end
        end
    end

    // Buffer payloads are qualified by the full flags and need no reset.
    always_ff @(posedge Clock) begin
        if (acc_a) begin
            a_nd_p0 <= bus.a_nd;
            a_di_p0 <= bus.a_di;
        end
        if (acc_b) begin
            b_nd_p0 <= bus.b_nd;
            b_di_p0 <= bus.b_di;
        end
    end

    always_comb begin
        pend = '0;
        for (int r = 0; r < NREG; r++) begin
            pend[r] = (a_full_p0 && (a_nd_p0 == ADDR_W'(r))) ||
                      (b_full_p0 && (b_nd_p0 == ADDR_W'(r))) ||
                      (vld_p1    && (nd_p1   == ADDR_W'(r)));
        end
    end

    assign bus.a_ready = a_ready;
    assign bus.b_ready = b_ready;
    assign bus.nd      = nd_p1;
    assign bus.di      = di_p1;
    assign bus.reg_we  = vld_p1;
    assign bus.pending = pend;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register-file model on the write channel.
module tb_regfile_wb_arbiter;
    logic Clock;
    logic Reset;
    int   chk_n;
    int   pass_n;
    logic [7:0] rf [4];

    regfile_wb_arbiter_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    regfile_wb_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (bus.reg_we) rf[bus.nd] <= bus.di;
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0; bus.a_nd = '0; bus.a_di = '0;
        bus.b_valid = 1'b0; bus.b_nd = '0; bus.b_di = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk_n++; if (bus.reg_we !== 1'b0) $display("FAIL rst_we got %0h want 0", bus.reg_we); else pass_n++;
        chk_n++; if (bus.nd !== 2'd0) $display("FAIL rst_nd got %0h want 0", bus.nd); else pass_n++;
        chk_n++; if (bus.di !== 8'h00) $display("FAIL rst_di got %0h want 0", bus.di); else pass_n++;
        chk_n++; if (bus.pending !== 4'b0000) $display("FAIL rst_pending got %b want 0000", bus.pending); else pass_n++;
        chk_n++; if (bus.a_ready !== 1'b1) $display("FAIL rst_a_ready got %0h want 1", bus.a_ready); else pass_n++;
        chk_n++; if (bus.b_ready !== 1'b1) $display("FAIL rst_b_ready got %0h want 1", bus.b_ready); else pass_n++;
    endtask

    task automatic test_single();
        do_reset();
        bus.a_valid = 1'b1; bus.a_nd = 2'd2; bus.a_di = 8'h5A;
        step();
        idle_inputs();
        chk_n++; if (bus.reg_we !== 1'b0) $display("FAIL single_we_e1 got %0h want 0", bus.reg_we); else pass_n++;
        chk_n++; if (bus.pending !== 4'b0100) $display("FAIL single_pend_e1 got %b want 0100", bus.pending); else pass_n++;
        step();
        chk_n++; if (bus.reg_we !== 1'b1) $display("FAIL single_we_e2 got %0h want 1", bus.reg_we); else pass_n++;
        chk_n++; if (bus.nd !== 2'd2) $display("FAIL single_nd got %0h want 2", bus.nd); else pass_n++;
        chk_n++; if (bus.di !== 8'h5A) $display("FAIL single_di got %0h want 5a", bus.di); else pass_n++;
        chk_n++; if (bus.pending !== 4'b0100) $display("FAIL single_pend_e2 got %b want 0100", bus.pending); else pass_n++;
        step();
        chk_n++; if (bus.reg_we !== 1'b0) $display("FAIL single_we_e3 got %0h want 0", bus.reg_we); else pass_n++;
        chk_n++; if (bus.pending !== 4'b0000) $display("FAIL single_pend_e3 got %b want 0000", bus.pending); else pass_n++;
        chk_n++; if (rf[2] !== 8'h5A) $display("FAIL single_rf2 got %0h want 5a", rf[2]); else pass_n++;
    endtask

    task automatic test_alternate();
        logic [1:0] exp_nd;
        do_reset();
        bus.a_valid = 1'b1; bus.a_nd = 2'd1; bus.a_di = 8'h11;
        bus.b_valid = 1'b1; bus.b_nd = 2'd3; bus.b_di = 8'h33;
        chk_n++; if ({bus.a_ready, bus.b_ready} !== 2'b11) $display("FAIL alt_ready_e0 got %b want 11", {bus.a_ready, bus.b_ready}); else pass_n++;
        step();
        chk_n++; if ({bus.a_ready, bus.b_ready} !== 2'b10) $display("FAIL alt_ready_e1 got %b want 10", {bus.a_ready, bus.b_ready}); else pass_n++;
        chk_n++; if (bus.reg_we !== 1'b0) $display("FAIL alt_we_e1 got %0h want 0", bus.reg_we); else pass_n++;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_nd = (i % 2 == 0) ? 2'd1 : 2'd3;
            chk_n++; if (bus.reg_we !== 1'b1 || bus.nd !== exp_nd)
                $display("FAIL alt_commit%0d got we=%0h nd=%0h want we=1 nd=%0h", i, bus.reg_we, bus.nd, exp_nd);
            else pass_n++;
            chk_n++; if ({bus.a_ready, bus.b_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL alt_ready%0d got %b", i, {bus.a_ready, bus.b_ready});
            else pass_n++;
        end
        idle_inputs();
    endtask

    task automatic test_age();
        do_reset();
        bus.b_valid = 1'b1; bus.b_nd = 2'd0; bus.b_di = 8'h22;
        step();
        idle_inputs();
        bus.a_valid = 1'b1; bus.a_nd = 2'd0; bus.a_di = 8'h44;
        step();
        idle_inputs();
        chk_n++; if (bus.reg_we !== 1'b1 || bus.di !== 8'h22) $display("FAIL age_first got we=%0h di=%0h want we=1 di=22", bus.reg_we, bus.di); else pass_n++;
        chk_n++; if (bus.pending !== 4'b0001) $display("FAIL age_pend got %b want 0001", bus.pending); else pass_n++;
        step();
        chk_n++; if (bus.reg_we !== 1'b1 || bus.di !== 8'h44) $display("FAIL age_second got we=%0h di=%0h want we=1 di=44", bus.reg_we, bus.di); else pass_n++;
        step();
        chk_n++; if (rf[0] !== 8'h44) $display("FAIL age_rf0 got %0h want 44", rf[0]); else pass_n++;
        chk_n++; if (bus.reg_we !== 1'b0) $display("FAIL age_idle got %0h want 0", bus.reg_we); else pass_n++;
    endtask

    task automatic test_tie_same_reg();
        do_reset();
        bus.a_valid = 1'b1; bus.a_nd = 2'd2; bus.a_di = 8'h01;
        bus.b_valid = 1'b1; bus.b_nd = 2'd2; bus.b_di = 8'h02;
        step();
        idle_inputs();
        step();
        chk_n++; if (bus.reg_we !== 1'b1 || bus.di !== 8'h01) $display("FAIL tie_first got we=%0h di=%0h want we=1 di=01", bus.reg_we, bus.di); else pass_n++;
        step();
        chk_n++; if (bus.reg_we !== 1'b1 || bus.nd !== 2'd2 || bus.di !== 8'h02)
            $display("FAIL tie_second got we=%0h nd=%0h di=%0h want we=1 nd=2 di=02", bus.reg_we, bus.nd, bus.di);
        else pass_n++;
        step();
        chk_n++; if (rf[2] !== 8'h02) $display("FAIL tie_rf2 got %0h want 02", rf[2]); else pass_n++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                bus.a_valid = 1'b1; bus.a_nd = 2'(c); bus.a_di = 8'hA0 + 8'(c);
                chk_n++; if (bus.a_ready !== 1'b1) $display("FAIL b2b_ready%0d got %0h want 1", c, bus.a_ready); else pass_n++;
            end else begin
                idle_inputs();
            end
            step();
            if (c >= 1 && c <= 4) begin
                chk_n++; if (bus.reg_we !== 1'b1 || bus.di !== 8'hA0 + 8'(c - 1))
                    $display("FAIL b2b_write%0d got we=%0h di=%0h want we=1 di=%0h", c, bus.reg_we, bus.di, 8'hA0 + 8'(c - 1));
                else pass_n++;
            end else if (c == 5) begin
                chk_n++; if (bus.reg_we !== 1'b0) $display("FAIL b2b_tail got %0h want 0", bus.reg_we); else pass_n++;
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.a_valid = 1'b1; bus.a_nd = 2'd1; bus.a_di = 8'h61;
        bus.b_valid = 1'b1; bus.b_nd = 2'd2; bus.b_di = 8'h62;
        step();
        step();
        chk_n++; if (bus.reg_we !== 1'b1 || bus.pending !== 4'b0110)
            $display("FAIL mid_pre got we=%0h pend=%b want we=1 pend=0110", bus.reg_we, bus.pending);
        else pass_n++;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        idle_inputs();
        chk_n++; if ({bus.reg_we, bus.nd, bus.di, bus.pending} !== 15'd0)
            $display("FAIL mid_rst got we=%0h nd=%0h di=%0h pend=%b want all 0", bus.reg_we, bus.nd, bus.di, bus.pending);
        else pass_n++;
        chk_n++; if ({bus.a_ready, bus.b_ready} !== 2'b11) $display("FAIL mid_ready got %b want 11", {bus.a_ready, bus.b_ready}); else pass_n++;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_n++; if (bus.reg_we !== 1'b0) $display("FAIL mid_quiet%0d got %0h want 0", i, bus.reg_we); else pass_n++;
        end
    endtask

    initial begin
        chk_n  = 0;
        pass_n = 0;
        Reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_age();
        test_tie_same_reg();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end
endmodule
